// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: requester indices, FSM states
// and the saturating-increment helper used by the optional statistics block.
package mem_arb_pkg;

   localparam int unsigned NUM_REQ = 3;
   localparam int unsigned REQ_LD  = 0;
   localparam int unsigned REQ_D   = 1;
   localparam int unsigned REQ_I   = 2;

   localparam int unsigned STAT_W  = 16;

   typedef enum logic {
      ARB,
      LOCKED
   } arb_state_t;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker between the CPU data port (D) and the
// instruction fetch port (I); the one not served last wins a tie.
module rr_pick2 (
   input  logic elig_d,
   input  logic elig_i,
   input  logic last_was_i,
   output logic grant_d,
   output logic grant_i
);

   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (elig_d && elig_i) begin
         grant_d = last_was_i;
         grant_i = !last_was_i;
      end else begin
         grant_d = elig_d;
         grant_i = elig_i;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: loader (with lock) > round-robin D/I.
// Optional grant/contention statistics are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          we,
   input  logic [NUM_REQ*ADDR_W-1:0]   addr,
   input  logic [NUM_REQ*DATA_W-1:0]   wdata,
   input  logic                        ld_lock,
   output logic [NUM_REQ-1:0]          ack,
   output logic [NUM_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]           rdata,
   output logic                        cpu_stall,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]           stat_grant_ld,
   output logic [STAT_W-1:0]           stat_grant_d,
   output logic [STAT_W-1:0]           stat_grant_i,
   output logic [STAT_W-1:0]           stat_conflict
`endif
);

   arb_state_t          state;
   arb_state_t          state_nxt;
   logic                last_was_i;
   logic [NUM_REQ-1:0]  elig;
   logic [NUM_REQ-1:0]  grant;
   logic                rr_d;
   logic                rr_i;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                sel_we;
   logic [DATA_W-1:0]   rdata_q;

   // A requester whose ack is on the bus this cycle is still showing the
   // request it was just granted for, so it sits out this arbitration.
   assign elig = req & ~ack;

   rr_pick2 u_rr_pick2 (
      .elig_d     (elig[REQ_D]),
      .elig_i     (elig[REQ_I]),
      .last_was_i (last_was_i),
      .grant_d    (rr_d),
      .grant_i    (rr_i)
   );

   always_comb begin
      grant     = '0;
      state_nxt = state;
      unique case (state)
         ARB: begin
            if (elig[REQ_LD]) begin
               grant[REQ_LD] = 1'b1;
            end else begin
               grant[REQ_D] = rr_d;
               grant[REQ_I] = rr_i;
            end
            if (ld_lock && req[REQ_LD]) state_nxt = LOCKED;
         end
         LOCKED: begin
            grant[REQ_LD] = elig[REQ_LD];
            if (!ld_lock) state_nxt = ARB;
         end
      endcase
   end

   always_comb begin
      sel_addr  = mem_addr;
      sel_wdata = mem_wdata;
      sel_we    = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) begin
            sel_addr  = addr[k*ADDR_W +: ADDR_W];
            sel_wdata = wdata[k*DATA_W +: DATA_W];
            sel_we    = we[k];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= ARB;
         last_was_i <= 1'b1;
         ack        <= '0;
         rvalid     <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_stall  <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state     <= state_nxt;
         ack       <= grant;
         rvalid    <= ack & {NUM_REQ{~mem_we}};
         mem_en    <= |grant;
         mem_we    <= sel_we;
         mem_addr  <= sel_addr;
         mem_wdata <= sel_wdata;
         cpu_stall <= (state_nxt == LOCKED) || grant[REQ_LD];
         if (grant[REQ_D])      last_was_i <= 1'b0;
         else if (grant[REQ_I]) last_was_i <= 1'b1;
         if (|rvalid) rdata_q <= mem_rdata;
      end
   end

   // Read data arrives from the memory in the rvalid cycle itself; it is
   // passed straight through then and held afterwards.
   assign rdata = (|rvalid) ? mem_rdata : rdata_q;

`ifdef MEM_ARB_STATS_EN
   logic [NUM_REQ-1:0] losers;
   assign losers = elig & ~grant;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stat_grant_ld <= '0;
         stat_grant_d  <= '0;
         stat_grant_i  <= '0;
         stat_conflict <= '0;
      end else begin
         if (grant[REQ_LD]) stat_grant_ld <= sat_inc(stat_grant_ld);
         if (grant[REQ_D])  stat_grant_d  <= sat_inc(stat_grant_d);
         if (grant[REQ_I])  stat_grant_i  <= sat_inc(stat_grant_i);
         if ($countones(losers) >= 2) stat_conflict <= sat_inc(stat_conflict);
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared each cycle against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 16;
   localparam int unsigned NR = 3;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [NR-1:0]     req = '0;
   logic [NR-1:0]     we = '0;
   logic [NR*AW-1:0]  addr = '0;
   logic [NR*DW-1:0]  wdata = '0;
   logic              ld_lock = 1'b0;
   logic [NR-1:0]     ack;
   logic [NR-1:0]     rvalid;
   logic [DW-1:0]     rdata;
   logic              cpu_stall;
   logic              mem_en;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata = '0;
`ifdef MEM_ARB_STATS_EN
   logic [15:0]       stat_grant_ld, stat_grant_d, stat_grant_i, stat_conflict;
`endif

   int n_err = 0;
   int n_checks = 0;

   logic [DW-1:0] mem    [0:(1<<AW)-1];
   logic [DW-1:0] shadow [0:(1<<AW)-1];

   // reference model state
   logic [NR-1:0] m_ack, m_pend, e_rvalid;
   logic          m_locked, m_last_i;
   logic [DW-1:0] m_pend_data, e_rdata, e_mem_wdata;
   logic [AW-1:0] e_mem_addr;
   logic          e_mem_en, e_mem_we, e_stall;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .ld_lock   (ld_lock),
      .ack       (ack),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .cpu_stall (cpu_stall),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef MEM_ARB_STATS_EN
      ,
      .stat_grant_ld (stat_grant_ld),
      .stat_grant_d  (stat_grant_d),
      .stat_grant_i  (stat_grant_i),
      .stat_conflict (stat_conflict)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] fill_val(input int i);
      return (i == 5) ? 16'h6002 : DW'(i * 32'h1357 + 32'h00A5);
   endfunction

   // synchronous single-port memory, read data valid one cycle after mem_en
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = fill_val(i);
      forever begin
         @(posedge CLK);
         if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input int k, input logic r, input logic w, input int a, input int d);
      req[k] = r;
      we[k]  = w;
      addr[k*AW +: AW]  = AW'(a);
      wdata[k*DW +: DW] = DW'(d);
   endtask

   task automatic drop_on_ack();
      for (int k = 0; k < 3; k++) if (ack[k]) req[k] = 1'b0;
   endtask

   task automatic model_reset();
      m_ack = '0; m_pend = '0; e_rvalid = '0;
      m_locked = 1'b0; m_last_i = 1'b1;
      m_pend_data = '0; e_rdata = '0; e_mem_wdata = '0; e_mem_addr = '0;
      e_mem_en = 1'b0; e_mem_we = 1'b0; e_stall = 1'b0;
   endtask

   task automatic check_outputs();
      chk("ack",       32'(ack),       32'(m_ack));
      chk("rvalid",    32'(rvalid),    32'(e_rvalid));
      chk("rdata",     32'(rdata),     32'(e_rdata));
      chk("mem_en",    32'(mem_en),    32'(e_mem_en));
      chk("mem_we",    32'(mem_we),    32'(e_mem_we));
      chk("mem_addr",  32'(mem_addr),  32'(e_mem_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
      chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
   endtask

   // One clock: decide this cycle's winner from the rules, advance, compare.
   task automatic cycle();
      logic [NR-1:0] el;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int win;
      el  = req & ~m_ack;
      win = -1;
      if (el[0]) win = 0;
      else if (!m_locked) begin
         if (el[1] && el[2]) win = m_last_i ? 1 : 2;
         else if (el[1])     win = 1;
         else if (el[2])     win = 2;
      end
      e_rvalid = m_pend;
      if (m_pend != '0) e_rdata = m_pend_data;
      m_pend   = '0;
      m_ack    = '0;
      e_mem_en = 1'b0;
      e_mem_we = 1'b0;
      if (win >= 0) begin
         a = addr[win*AW +: AW];
         d = wdata[win*DW +: DW];
         m_ack[win]  = 1'b1;
         e_mem_en    = 1'b1;
         e_mem_we    = we[win];
         e_mem_addr  = a;
         e_mem_wdata = d;
         if (we[win]) shadow[a] = d;
         else begin
            m_pend[win] = 1'b1;
            m_pend_data = shadow[a];
         end
         if (win == 1)      m_last_i = 1'b0;
         else if (win == 2) m_last_i = 1'b1;
      end
      m_locked = m_locked ? ld_lock : (ld_lock && req[0]);
      e_stall  = m_locked || (win == 0);
      @(posedge CLK);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      req = '0; we = '0; ld_lock = 1'b0;
      RST = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge CLK);
      #3;
      RST = 1'b1;
   endtask

   initial begin
      int n;
      logic got, seen_d, seen_i;
      for (int i = 0; i < (1 << AW); i++) shadow[i] = fill_val(i);
      #1;

      // reset, then reset landing while a D read is on the bus
      do_reset();
      set_cmd(1, 1'b1, 1'b0, 5, 0);
      cycle();
      chk("t1_ack_d", 32'(ack), 32'b010);
      req = '0;
      RST = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge CLK);
      #1;
      check_outputs();
      #2;
      RST = 1'b1;
      cycle();
      cycle();
      set_cmd(1, 1'b1, 1'b0, 5, 0);
      cycle();
      req[1] = 1'b0;
      cycle();
      chk("t1_rvalid_d", 32'(rvalid), 32'b010);
      chk("t1_rdata", 32'(rdata), 32'h6002);

      // D and I contending continuously
      do_reset();
      set_cmd(1, 1'b1, 1'b0, 3, 0);
      set_cmd(2, 1'b1, 1'b0, 7, 0);
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("t2_alternate", 32'(ack), (i % 2 == 0) ? 32'b010 : 32'b100);
      end
      req = '0;
      cycle();
      cycle();

      // LD write beats D and I; D then reads back the new word
      do_reset();
      set_cmd(0, 1'b1, 1'b1, 31, 16'h6002);
      set_cmd(1, 1'b1, 1'b0, 31, 0);
      set_cmd(2, 1'b1, 1'b0, 7, 0);
      cycle();
      chk("t3_ld_first", 32'(ack), 32'b001);
      chk("t3_stall", 32'(cpu_stall), 32'd1);
      req[0] = 1'b0;
      got = 1'b0; seen_d = 1'b0; seen_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (ack[1]) seen_d = 1'b1;
         if (ack[2]) seen_i = 1'b1;
         if (rvalid[1]) begin
            got = 1'b1;
            chk("t3_rdata_31", 32'(rdata), 32'h6002);
         end
         drop_on_ack();
      end
      chk("t3_d_read_seen", 32'(got), 32'd1);
      chk("t3_d_served", 32'(seen_d), 32'd1);
      chk("t3_i_served", 32'(seen_i), 32'd1);

      // locked LD burst of four writes
      do_reset();
      ld_lock = 1'b1;
      n = 0;
      set_cmd(0, 1'b1, 1'b1, 0, 16'hA000);
      set_cmd(1, 1'b1, 1'b0, 3, 0);
      set_cmd(2, 1'b1, 1'b0, 7, 0);
      for (int i = 0; i < 40 && n < 4; i++) begin
         cycle();
         chk("t4_cpu_held", 32'(ack[2:1]), 32'd0);
         if (ack[0]) begin
            n++;
            if (n < 4) set_cmd(0, 1'b1, 1'b1, n, 16'hA000 + n);
            else begin
               req[0]  = 1'b0;
               ld_lock = 1'b0;
            end
         end
      end
      chk("t4_burst_done", 32'(n), 32'd4);
      cycle();
      chk("t4_unlock_gap", 32'(ack[2:1]), 32'd0);
      cycle();
      chk("t4_cpu_served", 32'(ack[2:1] != 2'b00), 32'd1);
      for (int i = 0; i < 6; i++) begin
         drop_on_ack();
         cycle();
      end
      chk("t4_mem0", 32'(mem[0]), 32'hA000);
      chk("t4_mem3", 32'(mem[3]), 32'hA003);

      // lone requester holding req
      do_reset();
      set_cmd(2, 1'b1, 1'b0, 9, 0);
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("t5_every_other", 32'(ack[2]), 32'(i % 2 == 0));
      end
      req = '0;
      cycle();
      cycle();

      // random traffic; requesters change their command only when acked
      do_reset();
      for (int i = 0; i < 500; i++) begin
         for (int k = 0; k < 3; k++) begin
            if (!req[k] || ack[k]) begin
               set_cmd(k, $urandom_range(0, 99) < ((k == 0) ? 25 : 65),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 65535)));
            end
         end
         if ($urandom_range(0, 19) == 0) ld_lock = ~ld_lock;
         cycle();
      end
      req = '0;
      ld_lock = 1'b0;
      for (int i = 0; i < 4; i++) cycle();

`ifdef MEM_ARB_STATS_EN
      do_reset();
      set_cmd(0, 1'b1, 1'b0, 1, 0);
      for (int i = 0; i < 140010; i++) @(posedge CLK);
      #1;
      chk("stat_ld_saturated", 32'(stat_grant_ld), 32'hFFFF);
      chk("stat_d_zero", 32'(stat_grant_d), 32'd0);
      req = '0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single-port synchronous memory between three requesters: program loader (LD), CPU data port (D, for lw/sw) and CPU instruction fetch (I).
- The loader has absolute priority and can lock the memory for a burst, so a program image loads while the CPU is held.
- D and I alternate round-robin.
- Sits between the cpu core, the loader/debug port and the memory array.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 16, memory word width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- req  in  3  request per requester, index 0=LD, 1=D, 2=I.
- we  in  3  write enable per requester, qualified by req.
- addr  in  3*ADDR_W  packed addresses, requester k at bits [k*ADDR_W +: ADDR_W].
- wdata  in  3*DATA_W  packed write data, same packing as addr.
- ld_lock  in  1  loader requests exclusive ownership.
- ack  out  3  one-cycle pulse: command for that requester is on the memory bus this cycle.
- rvalid  out  3  one-cycle pulse: rdata holds that requester's read result.
- rdata  out  DATA_W  read data, shared by all requesters.
- cpu_stall  out  1  high while LD owns or has locked memory.
- mem_en  out  1  memory command strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0.

Behaviour:
- Reset (RST=0, async): ack=0, rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, cpu_stall=0, state=ARB, rr_last=I (so D wins the first tie). An in-flight read is discarded and never produces rvalid.
- Pipeline:
  - Cycle N: req is sampled and a winner chosen.
  - Cycle N+1: registered mem_* driven, ack[winner]=1.
  - Cycle N+2: rdata=mem_rdata, rvalid[winner]=1, reads only.
  - Writes produce no rvalid.
  - Throughput is one command per cycle.
- Eligibility: a requester acked in cycle N+1 is masked out of the cycle N+1 arbitration, so it cannot be double-granted on a stale req. Requesters drop or update req on the edge where they see ack.
- States:
  - ARB: if LD is eligible, grant LD; else if D and I are both eligible, grant the one that is not rr_last; else grant whichever is eligible. Update rr_last only on D/I grants. If ld_lock=1 and req[0]=1, go to LOCKED.
  - LOCKED: only LD can be granted; D and I are ignored. Stay in LOCKED while ld_lock=1. When ld_lock=0, return to ARB on the next cycle.
- cpu_stall is registered and is 1 in any cycle where the state is LOCKED or LD holds the current grant.
- No requests: mem_en=0, mem_addr and mem_wdata hold their last values.
- Simultaneous LD and D/I requests: LD wins. The losers keep req asserted and are served once LD is ineligible.
- mem_addr and mem_wdata are taken unchanged from the granted slice; there is no arithmetic and no wrap-around.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined: three 16-bit saturating grant counters (stat_grant_ld, stat_grant_d, stat_grant_i) and one 16-bit saturating contention counter (stat_conflict, incremented when two or more eligible requests lose in a cycle). All are exposed as output ports, cleared by reset, and stick at 16'hFFFF.
- When undefined: these ports and registers do not exist, and arbitration behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - requester indices REQ_LD=0, REQ_D=1, REQ_I=2;
  - NUM_REQ=3;
  - the state enum {ARB, LOCKED}.
- One sub-module, rr_pick2: a two-way round-robin picker with inputs D/I eligibility and rr_last, and output the grant.

Test Plan:
- Reset mid-read: D reads address 5, RST pulled low in cycle N+1 → no rvalid, all outputs 0, the first post-reset D read of address 5 returns the stored 16'h6002.
- D and I both request continuously, reading addresses 3 and 7 → acks alternate D, I, D, I; rvalid follows each ack by one cycle with the correct words.
- LD write to address 31 with 16'h6002 while D and I request → LD acked first and cpu_stall=1; D and I are served afterwards; a D read of 31 returns 16'h6002.
- ld_lock=1 burst of 4 LD writes (addresses 0–3) with D and I requesting → D and I get no ack until 1 cycle after ld_lock falls.
- Single requester holding req constantly → ack every other cycle, never on consecutive cycles.
- MEM_ARB_STATS_EN defined: 70000 LD grants → stat_grant_ld saturates at 16'hFFFF.
